// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder.
//   DEFAULT_DATA_W : default element/weight width
//   N              : array dimension (3x3)
//   NUM_WEIGHTS    : number of weight registers (N*N)
//   feeder_state_t : feeder control states
package systolic_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int N              = 3;
  localparam int NUM_WEIGHTS    = N * N;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    PULSE  = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/skew_delay.sv
// Fixed-depth delay line carrying a data word plus its valid bit.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_data   : data entering the line (zero for bubbles)
//   in_valid  : marks in_data as an accepted element
//   out_data  : data delayed by DEPTH cycles
//   out_valid : valid bit delayed by DEPTH cycles
module skew_delay #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  logic [DATA_W-1:0] data_pipe [DEPTH];
  logic [DEPTH-1:0]  valid_pipe;

  // Shift data and valid one stage per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_pipe[i] <= '0;
      end
      valid_pipe <= '0;
    end else begin
      data_pipe[0]  <= in_data;
      valid_pipe[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_pipe[i]  <= data_pipe[i-1];
        valid_pipe[i] <= valid_pipe[i-1];
      end
    end
  end

  assign out_data  = data_pipe[DEPTH-1];
  assign out_valid = valid_pipe[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Feeder for a 3x3 systolic array: collects nine weights and pulses them
// into the array, then streams input vectors with a diagonal skew
// (row 1 immediately, row 2 one cycle later, row 3 two cycles later).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   w_valid/w_ready/w_data       : weight beats, row-major w11..w33
//   vec_valid/vec_ready          : input vector handshake
//   vec_0..vec_2, vec_last       : vector elements and end-of-stream mark
//   weight_11..weight_33         : registered weights to the array
//   load_weights                 : one-cycle weight-latch pulse
//   input_11/input_21/input_31   : skewed row inputs
//   start                        : high while any skew stage holds data
//   feed_done                    : one-cycle end-of-stream pulse
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [DATA_W-1:0] vec_0,
  input  logic [DATA_W-1:0] vec_1,
  input  logic [DATA_W-1:0] vec_2,
  input  logic              vec_last,
  output logic [DATA_W-1:0] weight_11,
  output logic [DATA_W-1:0] weight_12,
  output logic [DATA_W-1:0] weight_13,
  output logic [DATA_W-1:0] weight_21,
  output logic [DATA_W-1:0] weight_22,
  output logic [DATA_W-1:0] weight_23,
  output logic [DATA_W-1:0] weight_31,
  output logic [DATA_W-1:0] weight_32,
  output logic [DATA_W-1:0] weight_33,
  output logic              load_weights,
  output logic [DATA_W-1:0] input_11,
  output logic [DATA_W-1:0] input_21,
  output logic [DATA_W-1:0] input_31,
  output logic              start,
  output logic              feed_done
);

  feeder_state_t     state;
  logic              wt_loaded;
  logic [3:0]        beat_cnt;
  logic              drain_cnt;
  logic [DATA_W-1:0] weights [NUM_WEIGHTS];
  logic [2:0]        last_pipe;

  logic              w_accept;
  logic              vec_accept;
  logic [DATA_W-1:0] row1_in;
  logic [DATA_W-1:0] row2_in;
  logic [DATA_W-1:0] d1_data;
  logic [DATA_W-1:0] d2_data;
  logic              d1_valid;
  logic              d2_valid;

  // Weights win over vectors when both are offered in IDLE.
  assign w_ready    = (state == IDLE) || (state == LOAD_W);
  assign vec_ready  = (state == STREAM) ||
                      ((state == IDLE) && wt_loaded && !w_valid);
  assign w_accept   = w_valid && w_ready;
  assign vec_accept = vec_valid && vec_ready;

  // Bubbles enter the skew as zeros so alignment is preserved.
  assign row1_in = vec_accept ? vec_1 : '0;
  assign row2_in = vec_accept ? vec_2 : '0;

  skew_delay #(.DATA_W(DATA_W), .DEPTH(1)) u_skew_row2 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (row1_in),
    .in_valid  (vec_accept),
    .out_data  (d1_data),
    .out_valid (d1_valid)
  );

  skew_delay #(.DATA_W(DATA_W), .DEPTH(2)) u_skew_row3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (row2_in),
    .in_valid  (vec_accept),
    .out_data  (d2_data),
    .out_valid (d2_valid)
  );

  // Control FSM: weight collection, latch pulse, streaming and drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wt_loaded    <= 1'b0;
      beat_cnt     <= 4'd0;
      drain_cnt    <= 1'b0;
      load_weights <= 1'b0;
      for (int i = 0; i < NUM_WEIGHTS; i++) begin
        weights[i] <= '0;
      end
    end else begin
      load_weights <= 1'b0;
      case (state)
        IDLE: begin
          if (w_accept) begin
            weights[0] <= w_data;
            beat_cnt   <= 4'd1;
            wt_loaded  <= 1'b0;
            state      <= LOAD_W;
          end else if (vec_accept) begin
            drain_cnt <= 1'b0;
            state     <= vec_last ? DRAIN : STREAM;
          end else begin
            state <= IDLE;
          end
        end
        LOAD_W: begin
          if (w_accept) begin
            weights[beat_cnt] <= w_data;
            if (beat_cnt == 4'd8) begin
              beat_cnt     <= 4'd0;
              load_weights <= 1'b1;
              state        <= PULSE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end else begin
            state <= LOAD_W;
          end
        end
        PULSE: begin
          wt_loaded <= 1'b1;
          state     <= IDLE;
        end
        STREAM: begin
          if (vec_accept && vec_last) begin
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            state <= STREAM;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state <= IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Skewed row outputs, compute enable and end-of-stream tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      input_11  <= '0;
      input_21  <= '0;
      input_31  <= '0;
      start     <= 1'b0;
      last_pipe <= 3'd0;
      feed_done <= 1'b0;
    end else begin
      input_11  <= vec_accept ? vec_0 : '0;
      input_21  <= d1_data;
      input_31  <= d2_data;
      start     <= vec_accept || d1_valid || d2_valid;
      // Last marker trails vec_2 by one stage so feed_done follows input_31.
      last_pipe <= {last_pipe[1:0], vec_accept && vec_last};
      feed_done <= last_pipe[2];
    end
  end

  assign weight_11 = weights[0];
  assign weight_12 = weights[1];
  assign weight_13 = weights[2];
  assign weight_21 = weights[3];
  assign weight_22 = weights[4];
  assign weight_23 = weights[5];
  assign weight_31 = weights[6];
  assign weight_32 = weights[7];
  assign weight_33 = weights[8];

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] w_data;
  logic          vec_valid;
  logic          vec_ready;
  logic [DW-1:0] vec_0, vec_1, vec_2;
  logic          vec_last;
  logic [DW-1:0] weight_11, weight_12, weight_13, weight_21, weight_22;
  logic [DW-1:0] weight_23, weight_31, weight_32, weight_33;
  logic          load_weights;
  logic [DW-1:0] input_11, input_21, input_31;
  logic          start;
  logic          feed_done;

  logic [DW-1:0] w_out [9];
  assign w_out[0] = weight_11;
  assign w_out[1] = weight_12;
  assign w_out[2] = weight_13;
  assign w_out[3] = weight_21;
  assign w_out[4] = weight_22;
  assign w_out[5] = weight_23;
  assign w_out[6] = weight_31;
  assign w_out[7] = weight_32;
  assign w_out[8] = weight_33;

  int checks   = 0;
  int failures = 0;

  systolic_feeder #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_0(vec_0), .vec_1(vec_1), .vec_2(vec_2), .vec_last(vec_last),
    .weight_11(weight_11), .weight_12(weight_12), .weight_13(weight_13),
    .weight_21(weight_21), .weight_22(weight_22), .weight_23(weight_23),
    .weight_31(weight_31), .weight_32(weight_32), .weight_33(weight_33),
    .load_weights(load_weights),
    .input_11(input_11), .input_21(input_21), .input_31(input_31),
    .start(start), .feed_done(feed_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // Mode flags plus a 4-deep history of what was accepted each cycle;
  // output row k shows element k of the vector accepted k cycles earlier.
  logic [DW-1:0] m_wt [9];
  bit            m_wt_loaded, m_pulse, m_stream, m_load_exp;
  int            m_beats, m_drain;
  bit            h_acc  [4];
  bit            h_last [4];
  logic [DW-1:0] h_e0 [4], h_e1 [4], h_e2 [4];

  function automatic bit m_w_ready();
    return !m_stream && (m_drain == 0) && !m_pulse;
  endfunction

  function automatic bit m_vec_ready(input bit wv);
    return m_stream || (m_wt_loaded && !wv && (m_drain == 0) && !m_pulse);
  endfunction

  function automatic bit exp_start();
    return h_acc[0] || h_acc[1] || h_acc[2];
  endfunction

  task automatic model_clear();
    m_wt_loaded = 0; m_pulse = 0; m_stream = 0; m_load_exp = 0;
    m_beats = 0; m_drain = 0;
    for (int i = 0; i < 9; i++) m_wt[i] = '0;
    for (int i = 0; i < 4; i++) begin
      h_acc[i] = 0; h_last[i] = 0; h_e0[i] = '0; h_e1[i] = '0; h_e2[i] = '0;
    end
  endtask

  // Advance one clock, updating the model with what the DUT should accept.
  task automatic tick();
    bit va, wa;
    va = vec_valid && m_vec_ready(w_valid);
    wa = w_valid && m_w_ready();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      m_load_exp = 0;
      if (m_pulse) begin
        m_pulse = 0;
        m_wt_loaded = 1;
      end else if (wa) begin
        m_wt[m_beats] = w_data;
        m_wt_loaded = 0;
        m_beats++;
        if (m_beats == 9) begin
          m_beats = 0; m_pulse = 1; m_load_exp = 1;
        end
      end
      if (va) begin
        if (vec_last) begin m_stream = 0; m_drain = 2; end
        else m_stream = 1;
      end else if (m_drain > 0) begin
        m_drain--;
      end
      for (int i = 3; i > 0; i--) begin
        h_acc[i] = h_acc[i-1]; h_last[i] = h_last[i-1];
        h_e0[i] = h_e0[i-1]; h_e1[i] = h_e1[i-1]; h_e2[i] = h_e2[i-1];
      end
      h_acc[0]  = va;
      h_last[0] = va && vec_last;
      h_e0[0]   = va ? vec_0 : '0;
      h_e1[0]   = va ? vec_1 : '0;
      h_e2[0]   = va ? vec_2 : '0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; w_valid = 0; w_data = '0; vec_valid = 0;
    vec_0 = '0; vec_1 = '0; vec_2 = '0; vec_last = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (w_out[i] !== '0) begin
        failures++; $display("FAIL reset_weight[%0d] got=%0h exp=0", i, w_out[i]);
      end
    end
    checks++;
    if ({input_11, input_21, input_31, start, feed_done, load_weights} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got in=%0h/%0h/%0h start=%0b done=%0b lw=%0b exp all 0",
               input_11, input_21, input_31, start, feed_done, load_weights);
    end
    #1;
    checks++;
    if (w_ready !== 1'b1 || vec_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got w=%0b v=%0b exp w=1 v=0", w_ready, vec_ready);
    end
  endtask

  task automatic test_no_weights();
    for (int c = 0; c < 4; c++) begin
      vec_valid = 1; vec_0 = DW'($urandom); vec_1 = DW'($urandom); vec_2 = DW'($urandom);
      #1;
      checks++;
      if (vec_ready !== 1'b0) begin
        failures++; $display("FAIL no_weights_ready got=%0b exp=0", vec_ready);
      end
      tick();
      checks++;
      if ({input_11, input_21, input_31, start} !== '0) begin
        failures++; $display("FAIL no_weights_out got=%0h/%0h/%0h start=%0b exp 0",
                             input_11, input_21, input_31, start);
      end
    end
    idle_inputs();
  endtask

  task automatic test_weight_load();
    for (int b = 1; b <= 9; b++) begin
      w_valid = 1; w_data = DW'(b);
      #1;
      checks++;
      if (w_ready !== 1'b1) begin
        failures++; $display("FAIL load_w_ready beat=%0d got=%0b exp=1", b, w_ready);
      end
      tick();
      checks++;
      if (load_weights !== (b == 9)) begin
        failures++; $display("FAIL load_pulse beat=%0d got=%0b exp=%0b", b, load_weights, b == 9);
      end
    end
    w_valid = 0;
    #1;
    checks++;
    if (w_ready !== 1'b0) begin
      failures++; $display("FAIL pulse_w_ready got=%0b exp=0", w_ready);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (w_out[i] !== DW'(i + 1)) begin
        failures++; $display("FAIL weight_val[%0d] got=%0d exp=%0d", i, w_out[i], i + 1);
      end
    end
    tick();
    checks++;
    if (load_weights !== 1'b0) begin
      failures++; $display("FAIL pulse_len got=%0b exp=0", load_weights);
    end
    #1;
    checks++;
    if (w_ready !== 1'b1 || vec_ready !== 1'b1) begin
      failures++; $display("FAIL loaded_ready got w=%0b v=%0b exp 1/1", w_ready, vec_ready);
    end
  endtask

  task automatic test_stream_basic();
    int e11 [6] = '{1, 4, 0, 0, 0, 0};
    int e21 [6] = '{0, 2, 5, 0, 0, 0};
    int e31 [6] = '{0, 0, 3, 6, 0, 0};
    bit efd [6] = '{0, 0, 0, 0, 1, 0};
    bit est [6] = '{1, 1, 1, 1, 0, 0};
    bit evr [6] = '{1, 1, 0, 0, 1, 1};
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c == 0) begin vec_valid = 1; vec_0 = 16'd1; vec_1 = 16'd2; vec_2 = 16'd3; end
      if (c == 1) begin vec_valid = 1; vec_0 = 16'd4; vec_1 = 16'd5; vec_2 = 16'd6; vec_last = 1; end
      #1;
      checks++;
      if (vec_ready !== evr[c]) begin
        failures++; $display("FAIL basic_vec_ready cyc=%0d got=%0b exp=%0b", c, vec_ready, evr[c]);
      end
      tick();
      checks++;
      if (input_11 !== DW'(e11[c]) || input_21 !== DW'(e21[c]) || input_31 !== DW'(e31[c])
          || feed_done !== efd[c] || start !== est[c]) begin
        failures++;
        $display("FAIL basic_stream cyc=%0d got=%0d/%0d/%0d done=%0b start=%0b exp=%0d/%0d/%0d done=%0b start=%0b",
                 c, input_11, input_21, input_31, feed_done, start, e11[c], e21[c], e31[c], efd[c], est[c]);
      end
    end
  endtask

  task automatic test_bubble();
    int e11 [7] = '{7, 0, 10, 0, 0, 0, 0};
    int e21 [7] = '{0, 8, 0, 11, 0, 0, 0};
    int e31 [7] = '{0, 0, 9, 0, 12, 0, 0};
    bit efd [7] = '{0, 0, 0, 0, 0, 1, 0};
    bit evr [7] = '{1, 1, 1, 0, 0, 1, 1};
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      if (c == 0) begin vec_valid = 1; vec_0 = 16'd7; vec_1 = 16'd8; vec_2 = 16'd9; end
      if (c == 2) begin vec_valid = 1; vec_0 = 16'd10; vec_1 = 16'd11; vec_2 = 16'd12; vec_last = 1; end
      #1;
      checks++;
      if (vec_ready !== evr[c]) begin
        failures++; $display("FAIL bubble_vec_ready cyc=%0d got=%0b exp=%0b", c, vec_ready, evr[c]);
      end
      tick();
      checks++;
      if (input_11 !== DW'(e11[c]) || input_21 !== DW'(e21[c]) || input_31 !== DW'(e31[c])
          || feed_done !== efd[c] || start !== exp_start()) begin
        failures++;
        $display("FAIL bubble_stream cyc=%0d got=%0d/%0d/%0d done=%0b start=%0b exp=%0d/%0d/%0d done=%0b start=%0b",
                 c, input_11, input_21, input_31, feed_done, start, e11[c], e21[c], e31[c], efd[c], exp_start());
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    for (int c = 0; c < 2; c++) begin
      vec_valid = 1; vec_last = 0;
      vec_0 = DW'($urandom); vec_1 = DW'($urandom); vec_2 = DW'($urandom);
      tick();
    end
    rst = 1;
    tick();
    idle_inputs();
    checks++;
    if ({input_11, input_21, input_31, start, feed_done, load_weights, weight_11, weight_33} !== '0) begin
      failures++;
      $display("FAIL mid_reset_out got in=%0h/%0h/%0h start=%0b done=%0b w11=%0h exp all 0",
               input_11, input_21, input_31, start, feed_done, weight_11);
    end
    #1;
    checks++;
    if (vec_ready !== 1'b0 || w_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset_ready got v=%0b w=%0b exp v=0 w=1", vec_ready, w_ready);
    end
    for (int c = 0; c < 4; c++) begin
      vec_valid = 1;
      tick();
      checks++;
      if (feed_done !== 1'b0 || start !== 1'b0) begin
        failures++; $display("FAIL mid_reset_quiet cyc=%0d done=%0b start=%0b exp 0", c, feed_done, start);
      end
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    logic [DW-1:0] first;
    for (int b = 0; b < 9; b++) begin
      w_valid = 1; w_data = DW'($urandom); tick();
    end
    idle_inputs();
    tick();
    first = DW'($urandom);
    w_valid = 1; w_data = first;
    vec_valid = 1; vec_0 = DW'($urandom); vec_1 = DW'($urandom); vec_2 = DW'($urandom);
    #1;
    checks++;
    if (vec_ready !== 1'b0 || w_ready !== 1'b1) begin
      failures++; $display("FAIL prio_ready got v=%0b w=%0b exp v=0 w=1", vec_ready, w_ready);
    end
    tick();
    checks++;
    if (weight_11 !== first || input_11 !== '0 || start !== 1'b0) begin
      failures++; $display("FAIL prio_accept got w11=%0h in11=%0h start=%0b exp w11=%0h in11=0 start=0",
                           weight_11, input_11, start, first);
    end
    w_valid = 0;
    #1;
    checks++;
    if (vec_ready !== 1'b0) begin
      failures++; $display("FAIL prio_unloaded got=%0b exp=0", vec_ready);
    end
    vec_valid = 0;
    for (int b = 0; b < 8; b++) begin
      w_valid = 1; w_data = DW'($urandom);
      tick();
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (w_out[i] !== m_wt[i]) begin
          failures++; $display("FAIL reload_weight[%0d] beat=%0d got=%0h exp=%0h", i, b, w_out[i], m_wt[i]);
        end
      end
    end
    idle_inputs();
    checks++;
    if (load_weights !== 1'b1) begin
      failures++; $display("FAIL reload_pulse got=%0b exp=1", load_weights);
    end
    tick();
  endtask

  task automatic test_random_stream();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      w_valid   = ($urandom_range(0, 3) == 0);
      w_data    = DW'($urandom);
      vec_valid = ($urandom_range(0, 3) != 0);
      vec_0     = DW'($urandom);
      vec_1     = DW'($urandom);
      vec_2     = DW'($urandom);
      vec_last  = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (vec_ready !== m_vec_ready(w_valid) || w_ready !== m_w_ready()) begin
        failures++; $display("FAIL rand_ready cyc=%0d got v=%0b w=%0b exp v=%0b w=%0b",
                             c, vec_ready, w_ready, m_vec_ready(w_valid), m_w_ready());
      end
      tick();
      checks++;
      if (input_11 !== h_e0[0] || input_21 !== h_e1[1] || input_31 !== h_e2[2]) begin
        failures++; $display("FAIL rand_rows cyc=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h",
                             c, input_11, input_21, input_31, h_e0[0], h_e1[1], h_e2[2]);
      end
      checks++;
      if (start !== exp_start() || feed_done !== h_last[3] || load_weights !== m_load_exp) begin
        failures++; $display("FAIL rand_ctrl cyc=%0d got start=%0b done=%0b lw=%0b exp %0b/%0b/%0b",
                             c, start, feed_done, load_weights, exp_start(), h_last[3], m_load_exp);
      end
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (w_out[i] !== m_wt[i]) begin
          failures++; $display("FAIL rand_weight[%0d] cyc=%0d got=%0h exp=%0h", i, c, w_out[i], m_wt[i]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_clear();
    idle_inputs();
    test_reset();
    test_no_weights();
    test_weight_load();
    test_stream_basic();
    test_bubble();
    test_reset_mid_stream();
    test_priority();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
